// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared types and encodings for the multi-cycle MIPS control unit
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ANDIEX  = 4'd11,
    S_ORIEX   = 4'd12,
    S_IMMWB   = 4'd13,
    S_JEX     = 4'd14
  } state_t;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'd0,
    ALUOP_SUB   = 3'd1,
    ALUOP_FUNCT = 3'd2,
    ALUOP_AND   = 3'd3,
    ALUOP_OR    = 3'd4
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_controller_aludec.sv
// ============================================================================
// aludec : maps the ALU-op class and R-type funct field to an ALU control code
// Revision : 1.0
// ============================================================================
`default_nettype none

module aludec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [2:0] aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_AND: alucontrol = ALU_AND;
      ALUOP_OR:  alucontrol = ALU_OR;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default:   alucontrol = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// mc_controller : Moore FSM sequencing the multi-cycle MIPS shared-memory datapath
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  logic       pcwrite, branch, branch_ne;
  logic [2:0] aluop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ANDI:      state_d = S_ANDIEX;
          OP_ORI:       state_d = S_ORIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;  // undefined opcode: silent 2-cycle no-op
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX, S_ANDIEX, S_ORIEX: state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    iord      = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = SRCB_B;
    zeroext   = 1'b0;
    pcsrc     = PCSRC_ALU;
    aluop     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        irwrite = 1'b1;
        alusrcb = SRCB_FOUR;
        pcwrite = 1'b1;
      end
      S_DECODE:  alusrcb = SRCB_BRANCH;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc     = PCSRC_ALUOUT;
        branch    = (state_q == S_BEQEX);
        branch_ne = (state_q == S_BNEEX);
      end
      S_ANDIEX, S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        zeroext = 1'b1;
        aluop   = (state_q == S_ANDIEX) ? ALUOP_AND : ALUOP_OR;
      end
      S_IMMWB:   regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen    = pcwrite | (branch & zero) | (branch_ne & ~zero);
  assign state_o = state_q;

  aludec u_aludec (
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (alucontrol)
  );

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// tb_mc_controller : randomized instruction streams against a per-instruction
// cycle model of the control unit. Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_controller;
  import mips_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] srcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
  } exp_t;

  logic       clk, reset, zero;
  logic [5:0] op, funct;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, zeroext;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;
  logic [19:0] obs;

  int n_pass = 0;
  int n_checks = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .state_o(state_o)
  );

  assign obs = {state_o, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
                alusrca, alusrcb, zeroext, pcsrc, alucontrol};

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit is_imm(input logic [5:0] o);
    return (o == OP_ADDI) || (o == OP_ANDI) || (o == OP_ORI);
  endfunction

  function automatic bit is_defined(input logic [5:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_RTYPE) || (o == OP_BEQ) ||
           (o == OP_BNE) || (o == OP_J) || is_imm(o);
  endfunction

  function automatic int cpi(input logic [5:0] o);
    if (o == OP_LW) return 5;
    if (o == OP_SW || o == OP_RTYPE || is_imm(o)) return 4;
    if (o == OP_BEQ || o == OP_BNE || o == OP_J) return 3;
    return 2;
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      FUNCT_SUB: return ALU_SUB;
      FUNCT_AND: return ALU_AND;
      FUNCT_OR:  return ALU_OR;
      FUNCT_SLT: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  // Expected controls for cycle k (0 = fetch) of an instruction.
  function automatic exp_t model(input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input int k);
    exp_t e;
    e = '0;
    e.aluc = ALU_ADD;
    if (k == 0) begin
      e.st = S_FETCH; e.irwrite = 1; e.srcb = SRCB_FOUR; e.pcen = 1;
    end else if (k == 1) begin
      e.st = S_DECODE; e.srcb = SRCB_BRANCH;
    end else if (o == OP_LW || o == OP_SW) begin
      if (k == 2) begin
        e.st = S_MEMADR; e.alusrca = 1; e.srcb = SRCB_IMM;
      end else if (o == OP_SW) begin
        e.st = S_MEMWR; e.iord = 1; e.memwrite = 1;
      end else if (k == 3) begin
        e.st = S_MEMRD; e.iord = 1;
      end else begin
        e.st = S_MEMWB; e.memtoreg = 1; e.regwrite = 1;
      end
    end else if (o == OP_RTYPE) begin
      if (k == 2) begin
        e.st = S_RTYPEEX; e.alusrca = 1; e.aluc = rtype_alu(f);
      end else begin
        e.st = S_RTYPEWB; e.regdst = 1; e.regwrite = 1;
      end
    end else if (o == OP_BEQ || o == OP_BNE) begin
      e.st = (o == OP_BEQ) ? S_BEQEX : S_BNEEX;
      e.alusrca = 1; e.aluc = ALU_SUB; e.pcsrc = PCSRC_ALUOUT;
      e.pcen = (o == OP_BEQ) ? z : ~z;
    end else if (is_imm(o)) begin
      if (k == 2) begin
        e.alusrca = 1; e.srcb = SRCB_IMM;
        if (o == OP_ADDI) e.st = S_ADDIEX;
        else if (o == OP_ANDI) begin e.st = S_ANDIEX; e.zeroext = 1; e.aluc = ALU_AND; end
        else begin e.st = S_ORIEX; e.zeroext = 1; e.aluc = ALU_OR; end
      end else begin
        e.st = S_IMMWB; e.regwrite = 1;
      end
    end else if (o == OP_J) begin
      e.st = S_JEX; e.pcsrc = PCSRC_JUMP; e.pcen = 1;
    end
    return e;
  endfunction

  // Starts on a falling edge with the FSM in FETCH; ends on a falling edge.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zsel);
    int rw, mw;
    exp_t e;
    rw = 0; mw = 0;
    op = o; funct = f;
    for (int k = 0; k < cpi(o); k++) begin
      zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : zsel[0];
      #1;
      e = model(o, f, zero, k);
      check($sformatf("op%b fn%b z%0b cyc%0d", o, f, zero, k), {12'b0, obs}, {12'b0, e});
      rw += int'(regwrite);
      mw += int'(memwrite);
      @(posedge clk);
      @(negedge clk);
    end
    check($sformatf("regwrite_cnt op%b", o), rw,
          (o == OP_LW || o == OP_RTYPE || is_imm(o)) ? 1 : 0);
    check($sformatf("memwrite_cnt op%b", o), mw, (o == OP_SW) ? 1 : 0);
  endtask

  logic [5:0] ops [9] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE,
                          OP_ADDI, OP_ANDI, OP_ORI, OP_J};
  logic [5:0] fns [6] = '{FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT, 6'b000111};

  initial begin
    exp_t e0;
    logic [5:0] ro, rf;
    reset = 1'b0; op = OP_SW; funct = 6'd0; zero = 1'b0;
    e0 = model(OP_SW, 6'd0, 1'b0, 0);
    #12;
    check("reset_vec", {12'b0, obs}, {12'b0, e0});
    #13;
    reset = 1'b1;

    run_instr(OP_LW,   6'd0,      -1);
    run_instr(OP_SW,   6'd0,      -1);
    run_instr(OP_BNE,  6'd0,       0);
    run_instr(OP_BNE,  6'd0,       1);
    run_instr(OP_BEQ,  6'd0,       1);
    run_instr(OP_BEQ,  6'd0,       0);
    run_instr(OP_ORI,  6'd0,      -1);
    run_instr(OP_ANDI, 6'd0,      -1);
    run_instr(OP_ADDI, 6'd0,      -1);
    run_instr(OP_RTYPE, FUNCT_SLT, -1);
    run_instr(OP_J,    6'd0,      -1);
    run_instr(6'b111111, 6'd0,    -1);

    // sw aborted by reset during address calculation
    op = OP_SW; funct = 6'd0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1;
    check("abort_pre_state", {28'b0, state_o}, {28'b0, 4'(S_MEMADR)});
    reset = 1'b0;
    #1;
    check("abort_vec", {12'b0, obs}, {12'b0, e0});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("abort_hold_vec", {12'b0, obs}, {12'b0, e0});
    end
    @(negedge clk);
    reset = 1'b1;
    run_instr(OP_LW, 6'd0, -1);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        ro = 6'($urandom);
        while (is_defined(ro)) ro = 6'($urandom);
      end else begin
        ro = ops[$urandom_range(0, 8)];
      end
      rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr(ro, rf, -1);
    end
    #1;
    check("final_state", {28'b0, state_o}, {28'b0, 4'(S_FETCH)});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
